// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a req/ack fetch to instruction
// memory, latches the returned word and presents it with imm16/ext_op for the
// immediate extender. Handles downstream stall and control-flow redirect.
// Optional feature macro: IF_ALIGN_FAULT_EN (sticky misaligned-redirect fault).
`ifndef EXT_ZERO
`define EXT_ZERO    2'b00
`endif
`ifndef EXT_SIGNED
`define EXT_SIGNED  2'b01
`endif
`ifndef EXT_HIGHPOS
`define EXT_HIGHPOS 2'b10
`endif

module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic [15:0] imm16,
    output logic [1:0]  ext_op,
    output logic        fetch_fault
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] tgt;

    // Redirect targets are forced to word alignment.
    assign tgt = {redirect_pc[31:2], 2'b00};

    // Fetch control: next PC, pending redirect target and latched instruction.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_pc_d     = pend_pc_q;
        instr_d       = instr_q;
        pc_out_d      = pc_out_q;
        instr_valid_d = instr_valid_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    if (redirect) begin
                        // Returned word belongs to the wrong path; refetch at target.
                        pc_d = tgt;
                    end else begin
                        instr_d       = imem_rdata;
                        pc_out_d      = pc_q;
                        pc_d          = pc_q + 32'd4;
                        instr_valid_d = 1'b1;
                        state_d       = S_HOLD;
                    end
                end else if (redirect) begin
                    // Request is outstanding and addr must stay stable: park the target.
                    pend_pc_d = tgt;
                    state_d   = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    instr_valid_d = 1'b0;
                    pc_d          = tgt;
                    state_d       = S_FETCH;
                end else if (!stall) begin
                    instr_valid_d = 1'b0;
                    state_d       = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (imem_ack) begin
                    // Stale word is discarded; the most recent redirect wins.
                    pc_d    = redirect ? tgt : pend_pc_q;
                    state_d = S_FETCH;
                end else if (redirect) begin
                    pend_pc_d = tgt;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            pend_pc_q     <= RESET_PC;
            instr_q       <= 32'd0;
            pc_out_q      <= RESET_PC;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_pc_q     <= pend_pc_d;
            instr_q       <= instr_d;
            pc_out_q      <= pc_out_d;
            instr_valid_q <= instr_valid_d;
        end
    end

`ifdef IF_ALIGN_FAULT_EN
    logic fault_q, fault_d;

    // Any accepted redirect with nonzero low bits latches a sticky fault.
    always_comb begin
        fault_d = fault_q;
        if (redirect && (state_q != S_IDLE) && (redirect_pc[1:0] != 2'b00)) begin
            fault_d = 1'b1;
        end
    end

    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fetch_fault = fault_q;
`else
    // Low address bits are silently dropped in this build.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign fetch_fault = 1'b0;
`endif

    assign imem_req    = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc_out      = pc_out_q;
    assign imm16       = instr_q[15:0];

    // Extender control decoded from the opcode field.
    always_comb begin
        ext_op = `EXT_SIGNED;
        case (instr_q[31:26])
            6'h0C, 6'h0D, 6'h0E: ext_op = `EXT_ZERO;
            6'h0F:               ext_op = `EXT_HIGHPOS;
            default:             ext_op = `EXT_SIGNED;
        endcase
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: directed scenarios followed by randomized
// traffic, all checked against a transaction-level reference model.
`ifndef EXT_ZERO
`define EXT_ZERO    2'b00
`endif
`ifndef EXT_SIGNED
`define EXT_SIGNED  2'b01
`endif
`ifndef EXT_HIGHPOS
`define EXT_HIGHPOS 2'b10
`endif

module tb_if_fetch_stage;

`ifdef IF_ALIGN_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif
    localparam logic [31:0] RPC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_ack, stall, redirect;
    logic [31:0] imem_rdata, redirect_pc;
    logic        imem_req, instr_valid, fetch_fault;
    logic [31:0] imem_addr, instr, pc_out;
    logic [15:0] imm16;
    logic [1:0]  ext_op;
    logic        req2, valid2, fault2;
    logic [31:0] addr2, instr2, pc_out2;
    logic [15:0] imm2;
    logic [1:0]  ext2;

    int checks = 0;
    int failures = 0;

    // Model state: what the fetch unit should be doing, in transaction terms.
    bit          m_idle, m_out, m_held, m_disc, m_fault;
    logic [31:0] m_next, m_req_addr, m_instr, m_pc_out;

    if_fetch_stage #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .instr(instr),
        .instr_valid(instr_valid), .pc_out(pc_out), .imm16(imm16),
        .ext_op(ext_op), .fetch_fault(fetch_fault)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .instr(instr2),
        .instr_valid(valid2), .pc_out(pc_out2), .imm16(imm2),
        .ext_op(ext2), .fetch_fault(fault2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_ext(input logic [31:0] w);
        logic [5:0] op;
        op = w[31:26];
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) return `EXT_ZERO;
        if (op == 6'h0F) return `EXT_HIGHPOS;
        return `EXT_SIGNED;
    endfunction

    // Advance the model by one clock edge given the inputs seen at that edge.
    task automatic model_edge(input bit a, input logic [31:0] d, input bit s,
                              input bit r, input logic [31:0] rp);
        logic [31:0] t;
        t = {rp[31:2], 2'b00};
        if (m_idle) begin
            m_idle = 0;
            m_out = 1;
            m_req_addr = m_next;
        end else begin
            if (r && rp[1:0] != 2'b00 && FAULT_EN) m_fault = 1;
            if (m_out) begin
                if (a) begin
                    if (r) begin
                        m_next = t; m_req_addr = t; m_disc = 0;
                    end else if (m_disc) begin
                        m_disc = 0; m_req_addr = m_next;
                    end else begin
                        m_out = 0; m_held = 1; m_instr = d;
                        m_pc_out = m_req_addr; m_next = m_req_addr + 32'd4;
                    end
                end else if (r) begin
                    m_disc = 1; m_next = t;
                end
            end else if (m_held) begin
                if (r) begin
                    m_held = 0; m_out = 1; m_next = t; m_req_addr = t;
                end else if (!s) begin
                    m_held = 0; m_out = 1; m_req_addr = m_next;
                end
            end
        end
    endtask

    task automatic cyc(input bit a, input logic [31:0] d, input bit s,
                       input bit r, input logic [31:0] rp);
        imem_ack = a; imem_rdata = d; stall = s; redirect = r; redirect_pc = rp;
        @(posedge clk);
        model_edge(a, d, s, r, rp);
        #1;
        chk("req", imem_req, m_out);
        chk("req2", req2, m_out);
        if (m_out) chk("addr", imem_addr, m_req_addr);
        chk("valid", instr_valid, m_held);
        if (m_held) begin
            chk("instr", instr, m_instr);
            chk("pc_out", pc_out, m_pc_out);
            chk("imm16", imm16, m_instr[15:0]);
            chk("ext_op", ext_op, exp_ext(m_instr));
        end
        chk("fault", fetch_fault, m_fault);
    endtask

    task automatic do_reset();
        imem_ack = 0; imem_rdata = 0; stall = 0; redirect = 0; redirect_pc = 0;
        #2;
        rst_n = 0;
        #1;
        chk("rst_instr", instr, 32'd0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_pc_out", pc_out, RPC);
        chk("rst_pc_out2", pc_out2, 32'hFFFF_FFFC);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_fault", fetch_fault, 1'b0);
        chk("rst_imm16", imm16, 16'd0);
        chk("rst_ext", ext_op, `EXT_SIGNED);
        @(posedge clk);
        #1;
        rst_n = 1;
        m_idle = 1; m_out = 0; m_held = 0; m_disc = 0; m_fault = 0;
        m_next = RPC; m_req_addr = RPC; m_instr = 0; m_pc_out = RPC;
    endtask

    initial begin
        logic [31:0] a5;
        bit ra, rs, rr;
        logic [31:0] rd, rp;

        do_reset();

        // Zero-wait memory: one instruction every second cycle.
        cyc(1, 32'h1111_0001, 0, 0, 0);
        chk("t1_addr0", imem_addr, 32'h3000);
        chk("t6_addr2_0", addr2, 32'hFFFF_FFFC);
        cyc(1, 32'h1111_0001, 0, 0, 0);
        chk("t1_pc0", pc_out, 32'h3000);
        cyc(1, 32'h2222_0002, 0, 0, 0);
        chk("t1_addr1", imem_addr, 32'h3004);
        chk("t6_addr2_1", addr2, 32'h0000_0000);
        cyc(1, 32'h2222_0002, 0, 0, 0);
        chk("t1_pc1", pc_out, 32'h3004);
        cyc(1, 32'h3333_0003, 0, 0, 0);
        chk("t1_addr2", imem_addr, 32'h3008);

        // Ack delayed three cycles: request and address held.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 32'hBAD0_0000, 0, 0, 0);
            chk("t2_req", imem_req, 1'b1);
            chk("t2_addr", imem_addr, 32'h3008);
        end
        cyc(1, 32'h4444_0004, 0, 0, 0);
        chk("t2_instr", instr, 32'h4444_0004);

        // Stall in HOLD for four cycles.
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 0, 0);
            chk("t3_valid", instr_valid, 1'b1);
            chk("t3_pc", pc_out, 32'h3008);
            chk("t3_noreq", imem_req, 1'b0);
        end
        cyc(0, 0, 0, 0, 0);
        chk("t3_next", imem_addr, 32'h300C);

        // Extender control decode.
        cyc(1, 32'h3C01_ABCD, 0, 0, 0);
        chk("t4_imm", imm16, 16'hABCD);
        chk("t4_lui", ext_op, `EXT_HIGHPOS);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 32'h3421_8000, 0, 0, 0);
        chk("t4_ori", ext_op, `EXT_ZERO);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 32'h2021_FFFF, 0, 0, 0);
        chk("t4_addi", ext_op, `EXT_SIGNED);
        cyc(0, 0, 0, 0, 0);

        // Redirect with a request outstanding: drain, discard, refetch.
        a5 = imem_addr;
        cyc(0, 0, 0, 1, 32'h0000_3100);
        chk("t5_hold_addr", imem_addr, a5);
        cyc(0, 0, 0, 0, 0);
        chk("t5_hold_addr2", imem_addr, a5);
        cyc(1, 32'hDEAD_BEEF, 0, 0, 0);
        chk("t5_dropped", instr_valid, 1'b0);
        chk("t5_new_addr", imem_addr, 32'h3100);
        cyc(1, 32'h5555_0005, 0, 0, 0);
        chk("t5_pc", pc_out, 32'h3100);

        // Misaligned redirect from HOLD.
        cyc(0, 0, 0, 1, 32'h0000_3102);
        chk("t6_aligned", imem_addr, 32'h3100);
        chk("t6_fault", fetch_fault, FAULT_EN);

        // Randomized traffic, with a reset dropped into the middle.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            ra = ($urandom_range(0, 2) != 0);
            rs = ($urandom_range(0, 2) == 0);
            rr = ($urandom_range(0, 7) == 0);
            rd = $urandom;
            rp = $urandom;
            cyc(ra, rd, rs, rr, rp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
